// File: rtl/fifo_read_arbiter_if.sv
// rtl/fifo_read_arbiter_if.sv - read-side bundle between the FIFO bank, the arbiter and the consumer
interface fifo_read_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int CH_W  = 2
);
    logic [N_CH-1:0]       empty;
    logic [N_CH*WIDTH-1:0] rdata;
    logic [N_CH-1:0]       read;
    logic [N_CH-1:0]       grant;
    logic [WIDTH-1:0]      m_data;
    logic [CH_W-1:0]       m_chan;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  empty, rdata, m_ready,
        output read, grant, m_data, m_chan, m_valid
    );

    modport slave (
        output empty, rdata, m_ready,
        input  read, grant, m_data, m_chan, m_valid
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// rtl/fifo_read_arbiter.sv - round-robin burst scheduler draining N_CH FIFOs into one tagged stream
module fifo_read_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int CH_W  = 2,
    parameter int BURST = 4
) (
    input  logic                i_read_clk,
    input  logic                i_rst,
    fifo_read_arbiter_if.master bus
);
    typedef enum logic {IDLE, SERVE} state_t;

    localparam logic [7:0] BURST_C = 8'(BURST);

    state_t           r_state, w_state_nxt;
    logic [CH_W-1:0]  r_owner, w_owner_nxt;
    logic [CH_W-1:0]  r_last, w_last_nxt;
    logic [N_CH-1:0]  r_grant, w_grant_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             r_inflight;
    logic [CH_W-1:0]  r_infl_chan;
    logic [WIDTH-1:0] r_data [2];
    logic [CH_W-1:0]  r_chan [2];
    logic [1:0]       r_occ;

    logic             w_pop, w_credit, w_issue, w_rotate, w_found;
    logic [CH_W-1:0]  w_base, w_pick;
    logic [WIDTH-1:0] w_rword;

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_CH) s = s - N_CH;
        return CH_W'(s);
    endfunction

    // Priority search starts just after the base channel; the base itself is checked last.
    assign w_base = (r_state == SERVE) ? r_owner : r_last;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (!bus.empty[wrap_add(w_base, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(w_base, k);
            end
        end
    end

    // Reads are credited against the skid buffer so it can never overflow.
    assign w_pop    = (r_occ != 2'd0) & bus.m_ready;
    assign w_credit = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        w_rotate    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt         = SERVE;
                    w_owner_nxt         = w_pick;
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_cnt_nxt           = '0;
                end
            end
            SERVE: begin
                w_issue  = (r_cnt != BURST_C) & ~bus.empty[r_owner] & w_credit;
                w_rotate = (r_cnt == BURST_C) | bus.empty[r_owner];
                if (w_issue) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end else if (w_rotate) begin
                    w_last_nxt = r_owner;
                    w_cnt_nxt  = '0;
                    if (w_found) begin
                        w_owner_nxt         = w_pick;
                        w_grant_nxt         = '0;
                        w_grant_nxt[w_pick] = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_rword = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_infl_chan == CH_W'(i)) w_rword = bus.rdata[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge i_read_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_last      <= CH_W'(N_CH - 1);
            r_grant     <= '0;
            r_cnt       <= '0;
            r_inflight  <= 1'b0;
            r_infl_chan <= '0;
            r_data[0]   <= '0;
            r_data[1]   <= '0;
            r_chan[0]   <= '0;
            r_chan[1]   <= '0;
            r_occ       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_grant     <= w_grant_nxt;
            r_cnt       <= w_cnt_nxt;
            r_inflight  <= w_issue;
            r_infl_chan <= r_owner;
            // The word strobed last cycle is on rdata now; entry 0 is always the head.
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data[0] <= w_rword;
                        r_chan[0] <= r_infl_chan;
                    end else begin
                        r_data[1] <= w_rword;
                        r_chan[1] <= r_infl_chan;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_data[0] <= r_data[1];
                    r_chan[0] <= r_chan[1];
                    r_occ     <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_data[0] <= w_rword;
                        r_chan[0] <= r_infl_chan;
                    end else begin
                        r_data[0] <= r_data[1];
                        r_chan[0] <= r_chan[1];
                        r_data[1] <= w_rword;
                        r_chan[1] <= r_infl_chan;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.read    = w_issue ? r_grant : '0;
    assign bus.grant   = r_grant;
    assign bus.m_valid = (r_occ != 2'd0);
    assign bus.m_data  = r_data[0];
    assign bus.m_chan  = r_chan[0];
endmodule
